// File: rtl/instruction_decode_pkg.sv
// +----------------------------------------------------------------------+
// | mips_defs : opcode/funct constants, ALU encodings, decode bundles     |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package mips_defs;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    reg_dst;
    logic    branch;
    logic    jump;
    alu_op_e alu_op;
    logic    illegal;
  } ctrl_t;

  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       pc_plus4;
    logic [XLEN-1:0]       rs_data;
    logic [XLEN-1:0]       rt_data;
    logic [XLEN-1:0]       imm;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       jump_target;
    ctrl_t                 ctrl;
  } idex_t;

  // Unsupported opcodes and R-type functs yield an all-zero bundle with only illegal set.
  function automatic ctrl_t decode_ctrl(input logic [5:0] op, input logic [5:0] funct);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        case (funct)
          FN_ADD:  c.alu_op = ALU_ADD;
          FN_SUB:  c.alu_op = ALU_SUB;
          FN_AND:  c.alu_op = ALU_AND;
          FN_OR:   c.alu_op = ALU_OR;
          FN_SLT:  c.alu_op = ALU_SLT;
          default: begin
            c         = '0;
            c.illegal = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.alu_src    = 1'b1;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      OP_J:    c.jump    = 1'b1;
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_decode_register_file.sv
// +----------------------------------------------------------------------+
// | register_file : 2R/1W register file, r0 hardwired, write-read bypass |
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module register_file #(
  parameter int REG_COUNT = 32,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs_q [REG_COUNT];
  logic [DATA_W-1:0] regs_d [REG_COUNT];
  logic              wr_live;

  assign wr_live = wr_en && (wr_addr != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_live) regs_d[wr_addr] = wr_data;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

  // Same-cycle write-back is forwarded so decode never sees a stale operand.
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (rd_addr_a != '0) rd_data_a = (wr_live && wr_addr == rd_addr_a) ? wr_data : regs_q[rd_addr_a];
    if (rd_addr_b != '0) rd_data_b = (wr_live && wr_addr == rd_addr_b) ? wr_data : regs_q[rd_addr_b];
  end

endmodule

`default_nettype wire

// File: rtl/instruction_decode.sv
// +----------------------------------------------------------------------+
// | instruction_decode : IF/ID register, decode, load-use hazard, ID/EX  |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module instruction_decode
  import mips_defs::*;
#(
  parameter int REG_COUNT = 32,
  parameter int DATA_W    = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] Instruction_Code,
  input  logic [DATA_W-1:0] PC_In,
  input  logic              In_Valid,
  input  logic              Flush,
  input  logic              WB_En,
  input  logic [4:0]        WB_Addr,
  input  logic [DATA_W-1:0] WB_Data,
  output logic              Stall_Req,
  output logic              Out_Valid,
  output logic [DATA_W-1:0] Out_PC_Plus4,
  output logic [DATA_W-1:0] Out_Rs_Data,
  output logic [DATA_W-1:0] Out_Rt_Data,
  output logic [DATA_W-1:0] Out_Imm,
  output logic [4:0]        Out_Rs,
  output logic [4:0]        Out_Rt,
  output logic [4:0]        Out_Rd,
  output logic [DATA_W-1:0] Out_Jump_Target,
  output logic              Out_Reg_Write,
  output logic              Out_Mem_Read,
  output logic              Out_Mem_Write,
  output logic              Out_Mem_To_Reg,
  output logic              Out_Alu_Src,
  output logic              Out_Reg_Dst,
  output logic              Out_Branch,
  output logic              Out_Jump,
  output logic [2:0]        Out_Alu_Op,
  output logic              Out_Illegal
);

  logic              ifid_valid_q, ifid_valid_d;
  logic [XLEN-1:0]   ifid_instr_q, ifid_instr_d;
  logic [XLEN-1:0]   ifid_pc_q,    ifid_pc_d;
  idex_t             ex_q, ex_d;

  logic [4:0]        id_rs, id_rt;
  logic [5:0]        id_op;
  logic [XLEN-1:0]   rs_data, rt_data, pc_plus4;
  logic              uses_rt, stall;

  assign id_op    = ifid_instr_q[31:26];
  assign id_rs    = ifid_instr_q[25:21];
  assign id_rt    = ifid_instr_q[20:16];
  assign pc_plus4 = ifid_pc_q + 32'd4;
  assign uses_rt  = (id_op == OP_RTYPE) || (id_op == OP_SW) || (id_op == OP_BEQ);

  register_file #(
    .REG_COUNT (REG_COUNT),
    .DATA_W    (DATA_W),
    .ADDR_W    (REG_ADDR_W)
  ) u_register_file (
    .Clk       (Clk),
    .Reset     (Reset),
    .rd_addr_a (id_rs),
    .rd_data_a (rs_data),
    .rd_addr_b (id_rt),
    .rd_data_b (rt_data),
    .wr_en     (WB_En),
    .wr_addr   (WB_Addr),
    .wr_data   (WB_Data)
  );

  // Load in ID/EX whose target feeds the instruction now in IF/ID.
  assign stall = ex_q.valid && ex_q.ctrl.mem_read && (ex_q.rt != '0) && ifid_valid_q &&
                 ((ex_q.rt == id_rs) || (uses_rt && ex_q.rt == id_rt)) && !Flush;

  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    if (Flush) begin
      ifid_valid_d = 1'b0;
    end else if (!stall) begin
      ifid_valid_d = In_Valid;
      ifid_instr_d = Instruction_Code;
      ifid_pc_d    = PC_In;
    end
  end

  always_comb begin
    ex_d = '0;
    if (ifid_valid_q && !stall && !Flush) begin
      ex_d.valid       = 1'b1;
      ex_d.pc_plus4    = pc_plus4;
      ex_d.rs_data     = rs_data;
      ex_d.rt_data     = rt_data;
      ex_d.imm         = {{16{ifid_instr_q[15]}}, ifid_instr_q[15:0]};
      ex_d.rs          = id_rs;
      ex_d.rt          = id_rt;
      ex_d.rd          = ifid_instr_q[15:11];
      ex_d.jump_target = {pc_plus4[31:28], ifid_instr_q[25:0], 2'b00};
      ex_d.ctrl        = decode_ctrl(id_op, ifid_instr_q[5:0]);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      ex_q         <= '0;
    end else begin
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ex_q         <= ex_d;
    end
  end

  assign Stall_Req       = stall;
  assign Out_Valid       = ex_q.valid;
  assign Out_PC_Plus4    = ex_q.pc_plus4;
  assign Out_Rs_Data     = ex_q.rs_data;
  assign Out_Rt_Data     = ex_q.rt_data;
  assign Out_Imm         = ex_q.imm;
  assign Out_Rs          = ex_q.rs;
  assign Out_Rt          = ex_q.rt;
  assign Out_Rd          = ex_q.rd;
  assign Out_Jump_Target = ex_q.jump_target;
  assign Out_Reg_Write   = ex_q.ctrl.reg_write;
  assign Out_Mem_Read    = ex_q.ctrl.mem_read;
  assign Out_Mem_Write   = ex_q.ctrl.mem_write;
  assign Out_Mem_To_Reg  = ex_q.ctrl.mem_to_reg;
  assign Out_Alu_Src     = ex_q.ctrl.alu_src;
  assign Out_Reg_Dst     = ex_q.ctrl.reg_dst;
  assign Out_Branch      = ex_q.ctrl.branch;
  assign Out_Jump        = ex_q.ctrl.jump;
  assign Out_Alu_Op      = ex_q.ctrl.alu_op;
  assign Out_Illegal     = ex_q.ctrl.illegal;

endmodule

`default_nettype wire

// File: tb/tb_instruction_decode.sv
// +----------------------------------------------------------------------+
// | tb_instruction_decode : directed + random bench with mnemonic model  |
// | Revision              : 1.0                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_instruction_decode;

  typedef struct packed {
    bit        valid;
    bit [31:0] pc4, rs_d, rt_d, imm;
    bit [4:0]  rs, rt, rd;
    bit [31:0] jt;
    bit        rw, mr, mw, m2r, asrc, rdst, br, jmp;
    bit [2:0]  aop;
    bit        ill;
  } ex_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr, pc, wb_data;
  logic        in_valid, flush, wb_en;
  logic [4:0]  wb_addr;

  logic        Stall_Req, Out_Valid;
  logic [31:0] Out_PC_Plus4, Out_Rs_Data, Out_Rt_Data, Out_Imm, Out_Jump_Target;
  logic [4:0]  Out_Rs, Out_Rt, Out_Rd;
  logic        Out_Reg_Write, Out_Mem_Read, Out_Mem_Write, Out_Mem_To_Reg;
  logic        Out_Alu_Src, Out_Reg_Dst, Out_Branch, Out_Jump, Out_Illegal;
  logic [2:0]  Out_Alu_Op;

  int n_checks = 0;
  int n_errors = 0;

  bit        m_ifid_v;
  bit [31:0] m_ifid_i, m_ifid_pc;
  ex_t       m_ex;
  bit [31:0] m_rf [32];
  bit        m_stall;

  always #5 clk = ~clk;

  instruction_decode dut (
    .Clk(clk), .Reset(rst_n), .Instruction_Code(instr), .PC_In(pc), .In_Valid(in_valid),
    .Flush(flush), .WB_En(wb_en), .WB_Addr(wb_addr), .WB_Data(wb_data),
    .Stall_Req(Stall_Req), .Out_Valid(Out_Valid), .Out_PC_Plus4(Out_PC_Plus4),
    .Out_Rs_Data(Out_Rs_Data), .Out_Rt_Data(Out_Rt_Data), .Out_Imm(Out_Imm),
    .Out_Rs(Out_Rs), .Out_Rt(Out_Rt), .Out_Rd(Out_Rd), .Out_Jump_Target(Out_Jump_Target),
    .Out_Reg_Write(Out_Reg_Write), .Out_Mem_Read(Out_Mem_Read), .Out_Mem_Write(Out_Mem_Write),
    .Out_Mem_To_Reg(Out_Mem_To_Reg), .Out_Alu_Src(Out_Alu_Src), .Out_Reg_Dst(Out_Reg_Dst),
    .Out_Branch(Out_Branch), .Out_Jump(Out_Jump), .Out_Alu_Op(Out_Alu_Op), .Out_Illegal(Out_Illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic string mnem(bit [31:0] i);
    case (i[31:26])
      0: case (i[5:0])
           32: return "add";  34: return "sub";  36: return "and";
           37: return "or";   42: return "slt";  default: return "?";
         endcase
      35: return "lw";  43: return "sw";  4: return "beq";
      8:  return "addi"; 2: return "j";
      default: return "?";
    endcase
  endfunction

  function automatic bit [31:0] m_read(bit [4:0] a);
    if (a == 0) return 0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_rf[a];
  endfunction

  function automatic ex_t model_decode(bit [31:0] i, bit [31:0] p);
    ex_t   e = '0;
    string m = mnem(i);
    e.valid = 1;
    e.pc4   = p + 4;
    e.rs    = i[25:21];
    e.rt    = i[20:16];
    e.rd    = i[15:11];
    e.rs_d  = m_read(e.rs);
    e.rt_d  = m_read(e.rt);
    e.imm   = $signed(i[15:0]);
    e.jt    = (e.pc4 & 32'hF000_0000) | ((i & 32'h03FF_FFFF) << 2);
    if (m == "add" || m == "sub" || m == "and" || m == "or" || m == "slt") begin
      e.rw = 1; e.rdst = 1;
      e.aop = (m == "add") ? 0 : (m == "sub") ? 1 : (m == "and") ? 2 : (m == "or") ? 3 : 4;
    end else if (m == "lw")   begin e.rw = 1; e.mr = 1; e.m2r = 1; e.asrc = 1; end
    else if (m == "sw")       begin e.mw = 1; e.asrc = 1; end
    else if (m == "beq")      begin e.br = 1; e.aop = 1; end
    else if (m == "addi")     begin e.rw = 1; e.asrc = 1; end
    else if (m == "j")        e.jmp = 1;
    else                      e.ill = 1;
    return e;
  endfunction

  function automatic bit model_hazard();
    string m = mnem(m_ifid_i);
    bit    src_rt = (m_ifid_i[31:26] == 0) || m == "sw" || m == "beq";
    return m_ex.valid && m_ex.mr && m_ex.rt != 0 && m_ifid_v && !flush &&
           (m_ex.rt == m_ifid_i[25:21] || (src_rt && m_ex.rt == m_ifid_i[20:16]));
  endfunction

  task automatic model_edge();
    ex_t nx = '0;
    if (!rst_n) begin
      m_ifid_v = 0; m_ifid_i = 0; m_ifid_pc = 0; m_ex = '0;
      for (int k = 0; k < 32; k++) m_rf[k] = 0;
      return;
    end
    if (m_ifid_v && !m_stall && !flush) nx = model_decode(m_ifid_i, m_ifid_pc);
    if (flush) m_ifid_v = 0;
    else if (!m_stall) begin m_ifid_v = in_valid; m_ifid_i = instr; m_ifid_pc = pc; end
    if (wb_en && wb_addr != 0) m_rf[wb_addr] = wb_data;
    m_ex = nx;
  endtask

  task automatic compare_all();
    check("stall",  Stall_Req,       m_stall);
    check("valid",  Out_Valid,       m_ex.valid);
    check("pc4",    Out_PC_Plus4,    m_ex.pc4);
    check("rs_d",   Out_Rs_Data,     m_ex.rs_d);
    check("rt_d",   Out_Rt_Data,     m_ex.rt_d);
    check("imm",    Out_Imm,         m_ex.imm);
    check("rs",     Out_Rs,          m_ex.rs);
    check("rt",     Out_Rt,          m_ex.rt);
    check("rd",     Out_Rd,          m_ex.rd);
    check("jt",     Out_Jump_Target, m_ex.jt);
    check("ctrl",   {Out_Reg_Write, Out_Mem_Read, Out_Mem_Write, Out_Mem_To_Reg,
                     Out_Alu_Src, Out_Reg_Dst, Out_Branch, Out_Jump},
                    {m_ex.rw, m_ex.mr, m_ex.mw, m_ex.m2r, m_ex.asrc, m_ex.rdst, m_ex.br, m_ex.jmp});
    check("alu_op", Out_Alu_Op,      m_ex.aop);
    check("ill",    Out_Illegal,     m_ex.ill);
  endtask

  // Compare on the falling edge, advance the model on the rising edge, return just after it.
  task automatic cycle();
    @(negedge clk);
    m_stall = model_hazard();
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic present(input logic [31:0] i, input logic [31:0] p);
    instr = i; pc = p; in_valid = 1;
  endtask

  initial begin
    bit [4:0]  r1, r2, r3;
    bit [31:0] enc;
    int        kind;
    rst_n = 0; instr = 0; pc = 0; in_valid = 0; flush = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0;
    m_stall = 0;
    @(posedge clk); model_edge(); #1;
    cycle(); cycle();
    rst_n = 1;
    cycle();
    check("rst_valid", Out_Valid, 0);
    check("rst_stall", Stall_Req, 0);
    check("rst_ctrl",  {Out_Reg_Write, Out_Mem_Read, Out_Jump, Out_Illegal, Out_Alu_Op}, 0);

    wb_en = 1; wb_addr = 8; wb_data = 5; cycle();
    wb_addr = 9; wb_data = 3;            cycle();
    wb_en = 0;
    present(32'h0109_5020, 32'h40); cycle();
    in_valid = 0;                   cycle();
    check("add_valid", Out_Valid, 1);
    check("add_rs_d",  Out_Rs_Data, 5);
    check("add_rt_d",  Out_Rt_Data, 3);
    check("add_rd",    Out_Rd, 10);
    check("add_ctrl",  {Out_Reg_Dst, Out_Reg_Write, Out_Alu_Op}, 5'b11_000);
    check("add_pc4",   Out_PC_Plus4, 32'h44);

    present(32'h8C08_0004, 32'h48); cycle();
    present(32'h0109_5822, 32'h4C); cycle();
    check("lu_stall_on", Stall_Req, 1);
    cycle();
    check("lu_bubble",    Out_Valid, 0);
    check("lu_stall_off", Stall_Req, 0);
    in_valid = 0; cycle();
    check("lu_sub_valid", Out_Valid, 1);
    check("lu_sub_alu",   Out_Alu_Op, 3'b001);

    present(32'h0120_0820, 32'h50); cycle();
    in_valid = 0; wb_en = 1; wb_addr = 9; wb_data = 32'hDEAD_BEEF; cycle();
    check("bypass_rs", Out_Rs_Data, 32'hDEAD_BEEF);
    wb_en = 0;
    present(32'h0000_1020, 32'h54); cycle();
    in_valid = 0; wb_en = 1; wb_addr = 0; wb_data = 32'h1234; cycle();
    wb_en = 0;
    check("r0_bypass", Out_Rs_Data, 0);
    present(32'h0000_1020, 32'h58); cycle();
    in_valid = 0; cycle();
    check("r0_read", Out_Rs_Data, 0);

    present(32'h8C08_0004, 32'h60); cycle();
    present(32'h0109_5822, 32'h64); cycle();
    flush = 1; #1;
    check("flush_stall", Stall_Req, 0);
    cycle();
    flush = 0; in_valid = 0;
    check("flush_bubble", Out_Valid, 0);
    cycle();
    check("flush_cleared", Out_Valid, 0);

    present(32'hFC00_0000, 32'h70); cycle();
    in_valid = 0; cycle();
    check("ill_valid", Out_Valid, 1);
    check("ill_flag",  Out_Illegal, 1);
    check("ill_ctrl",  {Out_Reg_Write, Out_Mem_Read, Out_Mem_Write, Out_Mem_To_Reg, Out_Alu_Src,
                        Out_Reg_Dst, Out_Branch, Out_Jump, Out_Alu_Op}, 0);
    present(32'h0800_0100, 32'h1000_0000); cycle();
    in_valid = 0; cycle();
    check("j_target", Out_Jump_Target, 32'h1000_0400);
    check("j_jump",   Out_Jump, 1);

    present(32'h8C08_0004, 32'h80); cycle();
    present(32'h0109_5822, 32'h84); cycle();
    check("rst_mid_on", Stall_Req, 1);
    rst_n = 0; cycle();
    check("rst_mid_off", Stall_Req, 0);
    rst_n = 1; in_valid = 0; cycle();

    pc = 32'h100;
    for (int n = 0; n < 2000; n++) begin
      if (!m_stall) begin
        r1 = $urandom_range(0, 7); r2 = $urandom_range(0, 7); r3 = $urandom_range(0, 7);
        kind = $urandom_range(0, 11);
        case (kind)
          0, 1, 2, 3, 4: enc = {6'd0, r1, r2, r3, 5'd0, 6'(kind == 0 ? 32 : kind == 1 ? 34 :
                                                         kind == 2 ? 36 : kind == 3 ? 37 : 42)};
          5:  enc = {6'd35, r1, r2, 16'($urandom)};
          6:  enc = {6'd43, r1, r2, 16'($urandom)};
          7:  enc = {6'd4,  r1, r2, 16'($urandom)};
          8:  enc = {6'd8,  r1, r2, 16'($urandom)};
          9:  enc = {6'd2,  26'($urandom)};
          10: enc = {6'd0, r1, r2, r3, 5'd0, 6'd7};
          default: enc = {6'd63, 26'($urandom)};
        endcase
        instr    = enc;
        pc       = pc + 4;
        in_valid = ($urandom_range(0, 9) != 0);
      end
      flush   = ($urandom_range(0, 15) == 0);
      wb_en   = $urandom_range(0, 1);
      wb_addr = $urandom_range(0, 7);
      wb_data = $urandom;
      rst_n   = ($urandom_range(0, 199) != 0);
      cycle();
    end
    rst_n = 1; flush = 0; wb_en = 0; in_valid = 0;
    cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
